// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter driving a shared active-low 2-to-4 decoder.
// Optional hold-time limit is compiled in with `define ARB_TIMEOUT_EN.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [3:0] REQ,
    output logic [3:0] GNT_L,
    output logic [1:0] SEL,
    output logic       G_L,
    output logic       BUSY,
    output logic       TIMEOUT,
    output logic [1:0] STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_l_q, gnt_l_d;
    logic       g_l_q, g_l_d;
    logic       busy_q, busy_d;
    logic       pick_valid;
    logic [1:0] pick_idx;

`ifdef ARB_TIMEOUT_EN
    logic [3:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // Scan from the highest offset down so the lowest offset from PTR wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (REQ[ptr_q + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        sel_d   = sel_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_GAP: begin
                if (pick_valid) begin
                    state_d = S_GRANT;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx + 2'd1;
                    sel_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 4'd0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // A voluntary release wins over a coincident timeout.
                if (!REQ[owner_q]) begin
                    state_d = S_GAP;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_q == 4'(MAX_HOLD - 1)) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 4'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        gnt_l_d = 4'hF;
        if (state_d == S_GRANT) begin
            gnt_l_d = ~(4'b0001 << owner_d);
        end
        g_l_d  = (state_d != S_GRANT);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            sel_q   <= 2'd0;
            gnt_l_q <= 4'hF;
            g_l_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            gnt_l_q <= gnt_l_d;
            g_l_q   <= g_l_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            hold_q    <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT_L     = gnt_l_q;
    assign SEL       = sel_q;
    assign G_L       = g_l_q;
    assign BUSY      = busy_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios plus a long random run against a behavioural model.
module tb_rr_arbiter4;
    localparam int MH = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CLK;
    logic       RESET_L;
    logic [3:0] REQ;
    logic [3:0] GNT_L;
    logic [1:0] SEL;
    logic       G_L;
    logic       BUSY;
    logic       TIMEOUT;
    logic [1:0] STATE_DBG;

    int checks = 0;
    int passes = 0;

    // Behavioural model: who owns the resource, whether a gap cycle is showing, rotation pointer.
    bit m_grant;
    bit m_gap;
    bit m_to;
    int m_ptr;
    int m_owner;
    int m_sel;
    int m_hold;

    rr_arbiter4 #(.MAX_HOLD(MH)) dut (
        .CLK(CLK), .RESET_L(RESET_L), .REQ(REQ), .GNT_L(GNT_L), .SEL(SEL),
        .G_L(G_L), .BUSY(BUSY), .TIMEOUT(TIMEOUT), .STATE_DBG(STATE_DBG)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_grant = 0; m_gap = 0; m_to = 0;
        m_ptr = 0; m_owner = 0; m_sel = 0; m_hold = 0;
    endtask

    task automatic model_update(input logic [3:0] r);
        m_to = 1'b0;
        if (m_grant) begin
            if (r[m_owner] == 1'b0) begin
                m_grant = 0; m_gap = 1;
            end else if (TO_EN && m_hold == MH - 1) begin
                m_grant = 0; m_gap = 1; m_to = 1;
            end else begin
                m_hold = m_hold + 1;
            end
        end else begin
            m_gap = 0;
            if (r != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (r[i] && !m_grant) begin
                        m_owner = i;
                        m_grant = 1;
                    end
                end
                m_ptr  = (m_owner + 1) % 4;
                m_sel  = m_owner;
                m_hold = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt_l();
        logic [3:0] one;
        one = 4'b0001 << m_owner;
        return m_grant ? ~one : 4'hF;
    endfunction

    task automatic step(input logic [3:0] r);
        REQ = r;
        model_update(r);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RESET_L = 1'b0;
        REQ = 4'b0000;
        @(negedge CLK);
        RESET_L = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        RESET_L = 1'b0;
        REQ = 4'b1111;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (GNT_L !== 4'hF) $display("FAIL reset_gnt_l got %b want 1111", GNT_L); else passes++;
        checks++; if (SEL !== 2'd0) $display("FAIL reset_sel got %b want 00", SEL); else passes++;
        checks++; if (G_L !== 1'b1) $display("FAIL reset_g_l got %b want 1", G_L); else passes++;
        checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else passes++;
        checks++; if (TIMEOUT !== 1'b0) $display("FAIL reset_timeout got %b want 0", TIMEOUT); else passes++;
        REQ = 4'b0000;
        RESET_L = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        apply_reset();
        step(4'b0100);
        checks++; if (GNT_L !== 4'b1011) $display("FAIL single_gnt_l got %b want 1011", GNT_L); else passes++;
        checks++; if (SEL !== 2'b10) $display("FAIL single_sel got %b want 10", SEL); else passes++;
        checks++; if (G_L !== 1'b0) $display("FAIL single_g_l got %b want 0", G_L); else passes++;
        checks++; if (BUSY !== 1'b1) $display("FAIL single_busy got %b want 1", BUSY); else passes++;
        step(4'b0000);
        checks++; if (GNT_L !== 4'hF || BUSY !== 1'b1 || G_L !== 1'b1)
            $display("FAIL single_gap got gnt_l=%b busy=%b g_l=%b want 1111/1/1", GNT_L, BUSY, G_L); else passes++;
        checks++; if (SEL !== 2'b10) $display("FAIL single_gap_sel_hold got %b want 10", SEL); else passes++;
        step(4'b0000);
        checks++; if (GNT_L !== 4'hF || BUSY !== 1'b0)
            $display("FAIL single_idle got gnt_l=%b busy=%b want 1111/0", GNT_L, BUSY); else passes++;
    endtask

    task automatic test_rotation();
        int order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] want;
        apply_reset();
        for (int g = 0; g < 5; g++) begin
            want = 4'hF ^ (4'b0001 << order[g]);
            for (int c = 0; c < 3; c++) begin
                step(4'b1111);
                checks++; if (GNT_L !== want)
                    $display("FAIL rotation_grant%0d_cycle%0d got %b want %b", g, c, GNT_L, want); else passes++;
            end
            step(4'b1111 & ~(4'b0001 << order[g]));
            checks++; if (GNT_L !== 4'hF || BUSY !== 1'b1)
                $display("FAIL rotation_gap%0d got gnt_l=%b busy=%b want 1111/1", g, GNT_L, BUSY); else passes++;
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(4'b0100);
        checks++; if (GNT_L !== 4'b1011) $display("FAIL wrap_first got %b want 1011", GNT_L); else passes++;
        step(4'b0000);
        step(4'b0101);
        checks++; if (GNT_L !== 4'b1110) $display("FAIL wrap_zero got %b want 1110", GNT_L); else passes++;
        step(4'b0100);
        checks++; if (GNT_L !== 4'hF) $display("FAIL wrap_gap got %b want 1111", GNT_L); else passes++;
        step(4'b0100);
        checks++; if (GNT_L !== 4'b1011) $display("FAIL wrap_two got %b want 1011", GNT_L); else passes++;
    endtask

    task automatic test_timeout();
        int held;
        apply_reset();
        held = 0;
        step(4'b0010);
        for (int c = 0; c < 20; c++) begin
            if (GNT_L !== 4'b1101) break;
            held++;
            checks++; if (TIMEOUT !== 1'b0) $display("FAIL timeout_during_grant got %b want 0", TIMEOUT); else passes++;
            step(4'b0010);
        end
`ifdef ARB_TIMEOUT_EN
        checks++; if (held != MH) $display("FAIL timeout_hold_len got %0d want %0d", held, MH); else passes++;
        checks++; if (GNT_L !== 4'hF || TIMEOUT !== 1'b1)
            $display("FAIL timeout_gap got gnt_l=%b timeout=%b want 1111/1", GNT_L, TIMEOUT); else passes++;
        step(4'b0010);
        checks++; if (GNT_L !== 4'b1101 || TIMEOUT !== 1'b0)
            $display("FAIL timeout_regrant got gnt_l=%b timeout=%b want 1101/0", GNT_L, TIMEOUT); else passes++;
        apply_reset();
        for (int c = 0; c < MH; c++) step(4'b0010);
        step(4'b0000);
        checks++; if (GNT_L !== 4'hF || TIMEOUT !== 1'b0)
            $display("FAIL timeout_release_wins got gnt_l=%b timeout=%b want 1111/0", GNT_L, TIMEOUT); else passes++;
`else
        checks++; if (held != 20) $display("FAIL timeout_held_forever got %0d want 20", held); else passes++;
`endif
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(4'b0010);
        step(4'b0010);
        checks++; if (GNT_L !== 4'b1101) $display("FAIL async_pre got %b want 1101", GNT_L); else passes++;
        #2 RESET_L = 1'b0;
        #1;
        checks++; if (GNT_L !== 4'hF || G_L !== 1'b1 || BUSY !== 1'b0)
            $display("FAIL async_drop got gnt_l=%b g_l=%b busy=%b want 1111/1/0", GNT_L, G_L, BUSY); else passes++;
        REQ = 4'b1000;
        #1 RESET_L = 1'b1;
        model_reset();
        model_update(4'b1000);
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (GNT_L !== 4'b0111 || SEL !== 2'b11)
            $display("FAIL async_regrant got gnt_l=%b sel=%b want 0111/11", GNT_L, SEL); else passes++;
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] mask;
        logic [3:0] prev_gnt;
        logic [1:0] prev_sel;
        logic       prev_g_l;
        int         waits[4];
        apply_reset();
        r = 4'b0000;
        prev_gnt = 4'hF; prev_sel = 2'd0; prev_g_l = 1'b1;
        for (int i = 0; i < 4; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            mask = 4'b0000;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) mask[b] = 1'b1;
            r = r ^ mask;
            step(r);
            checks++; if (GNT_L !== exp_gnt_l())
                $display("FAIL rand_gnt_l cyc %0d got %b want %b", cyc, GNT_L, exp_gnt_l()); else passes++;
            checks++; if (SEL !== 2'(m_sel)) $display("FAIL rand_sel cyc %0d got %0d want %0d", cyc, SEL, m_sel); else passes++;
            checks++; if (G_L !== !m_grant) $display("FAIL rand_g_l cyc %0d got %b want %b", cyc, G_L, !m_grant); else passes++;
            checks++; if (BUSY !== (m_grant || m_gap))
                $display("FAIL rand_busy cyc %0d got %b want %b", cyc, BUSY, (m_grant || m_gap)); else passes++;
            checks++; if (TIMEOUT !== m_to) $display("FAIL rand_timeout cyc %0d got %b want %b", cyc, TIMEOUT, m_to); else passes++;
            checks++; if ($countones(~GNT_L) > 1) $display("FAIL rand_onehot cyc %0d got %b want at most one low", cyc, GNT_L); else passes++;
            if (prev_g_l == 1'b0 && G_L == 1'b0) begin
                checks++; if (GNT_L !== prev_gnt)
                    $display("FAIL rand_break_before_make cyc %0d got %b want %b", cyc, GNT_L, prev_gnt); else passes++;
            end
            for (int i = 0; i < 4; i++) if (!r[i]) waits[i] = 0;
            if (prev_g_l == 1'b1 && G_L == 1'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (i == int'(SEL)) waits[i] = 0;
                    else if (r[i]) begin
                        waits[i]++;
                        checks++; if (waits[i] > 3)
                            $display("FAIL rand_starve req %0d cyc %0d got %0d waits want <=3", i, cyc, waits[i]); else passes++;
                    end
                end
            end
            prev_gnt = GNT_L; prev_sel = SEL; prev_g_l = G_L;
        end
    endtask

    initial begin
        RESET_L = 1'b0;
        REQ = 4'b0000;
        model_reset();
        @(negedge CLK);
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 8, the maximum number of consecutive cycles one grant may be held (legal range 2..15).
REQ-002 The block SHALL have a port CLK, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have a port RESET_L, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have a port REQ, input, 4 bits: active-high request, one bit per requester 0..3.
REQ-005 The block SHALL have a port GNT_L, output, 4 bits: active-low one-hot grant, decoder-style; GNT_L[i]=0 means requester i owns the shared resource.
REQ-006 The block SHALL have a port SEL, output, 2 bits: encoded owner index {B,A}, which drives the select inputs of the shared 2-to-4 decoder.
REQ-007 The block SHALL have a port G_L, output, 1 bit: active-low decoder enable, 0 exactly when a grant is active.
REQ-008 The block SHALL have a port BUSY, output, 1 bit: 1 while in GRANT or GAP.
REQ-009 The block SHALL have a port TIMEOUT, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-011 All outputs SHALL be registered, so a grant becomes visible one cycle after the REQ sample that caused it.
REQ-012 In IDLE or GAP, when REQ is nonzero, the FSM SHALL select the first set REQ bit searching PTR, PTR+1, ... modulo 4, latch it as OWNER, and go to GRANT.
REQ-013 In IDLE or GAP, when REQ is 0000, the FSM SHALL go to (or stay in) IDLE.
REQ-014 On entry to GRANT, PTR SHALL update to (OWNER+1) mod 4, as a 2-bit wrap-around.
REQ-015 In GRANT, the FSM SHALL drive GNT_L = ~(1<<OWNER), SEL = OWNER and G_L = 0.
REQ-016 In IDLE and GAP, the FSM SHALL drive GNT_L = 1111 and G_L = 1; SEL SHALL hold its last value.
REQ-017 In GRANT, when REQ[OWNER] is sampled 0, the FSM SHALL go to GAP; this provides exactly one break-before-make cycle with no active grant.
REQ-018 Changes on REQ bits other than REQ[OWNER] during GRANT SHALL have no effect on the grant.
REQ-019 GAP SHALL last exactly one cycle, and arbitration SHALL be performed in it per REQ-012/REQ-013.
REQ-020 A requester still asserting REQ after a release SHALL be granted again only after lower-priority rotation, per PTR.
REQ-021 At most one GNT_L bit SHALL be 0 in any cycle.
REQ-022 GNT_L SHALL never equal 0000.
REQ-023 If all four REQ bits are asserted continuously, the FSM SHALL grant in order 0,1,2,3,0,... (from reset), with one GAP cycle between grants.

Reset
REQ-024 While RESET_L=0, the block SHALL force, immediately and independent of CLK: state=IDLE, PTR=00, OWNER=00, SEL=00, GNT_L=1111, G_L=1, BUSY=0, TIMEOUT=0, and hold counter=0.
REQ-025 Reset asserted mid-GRANT SHALL drop the grant asynchronously.
REQ-026 After RESET_L rises, the first arbitration SHALL occur at the first rising CLK edge, using PTR=00.

Configuration
REQ-027 With ARB_TIMEOUT_EN defined, a 4-bit hold counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-028 With ARB_TIMEOUT_EN defined, when the owner has held for MAX_HOLD cycles, the FSM SHALL go to GAP regardless of REQ[OWNER], with TIMEOUT=1 during that GAP cycle only.
REQ-029 With ARB_TIMEOUT_EN defined, a simultaneous voluntary release and timeout SHALL be treated as a release, with TIMEOUT=0.
REQ-030 Without ARB_TIMEOUT_EN, the counter SHALL be absent, TIMEOUT SHALL be constant 0, and a grant SHALL be held until REQ[OWNER] drops.

Verification
REQ-031 Reset, then REQ=0100 held -> next edge: GNT_L=1011, SEL=10, G_L=0, BUSY=1; REQ drops -> GAP for 1 cycle (GNT_L=1111) then IDLE, BUSY=0.
REQ-032 REQ=1111 held, each owner dropping and reasserting its REQ after 3 grant cycles -> grant order 0,1,2,3,0 with exactly one GAP (GNT_L=1111) cycle between grants.
REQ-033 PTR=11 after granting 2; REQ=0101 -> requester 0 is granted (wrap-around), then requester 2.
REQ-034 With ARB_TIMEOUT_EN and MAX_HOLD=8, REQ=0010 held permanently -> GNT_L=1101 for exactly 8 cycles, then GAP with TIMEOUT=1, then regrant of requester 1; without the macro, the grant is held indefinitely and TIMEOUT stays 0.
REQ-035 RESET_L pulsed low mid-GRANT between clock edges -> GNT_L=1111 and G_L=1 immediately; after release, REQ=1000 -> requester 3 is granted (PTR=00 search).
REQ-036 Random REQ for 10,000 cycles -> GNT_L never has two bits low, every grant is preceded by IDLE or GAP, and no requester with REQ held waits more than 3 grants.
